reset_start_sequencer: RTL

- Sits between the board's reset sources and the flappy_space game core.
- Conditions the raw active-low push button: 2-flop synchroniser plus debouncer.
- Stretches the core reset, then releases it only on a video frame boundary.
- After release, turns short button presses into one-cycle game events; a long press re-enters reset.

---
 rtl/reset_start_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/reset_start_sequencer.sv
// Reset/start sequencer for the game core: synchronises and debounces the push button,
// stretches and frame-aligns the core reset, and turns presses into one-cycle game events.
module reset_start_sequencer #(
  parameter int DEBOUNCE_CYCLES   = 315000,
  parameter int STRETCH_CYCLES    = 1024,
  parameter int LONG_PRESS_CYCLES = 63000000,
  parameter int ALIGN_TO_FRAME    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_n,
  input  logic       frame_start,
  output logic       core_reset,
  output logic       ready,
  output logic       button_event,
  output logic [1:0] state
);

  localparam int DB_W  = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
  localparam int STR_W = (STRETCH_CYCLES    > 1) ? $clog2(STRETCH_CYCLES)    : 1;
  localparam int LP_W  = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);
  localparam logic [STR_W-1:0] STR_LAST = STR_W'(STRETCH_CYCLES - 1);
  localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);
  localparam logic [LP_W-1:0]  LP_LAST  = LP_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [LP_W-1:0]  LP_ONE   = LP_W'(1);

  localparam logic [1:0] HOLD    = 2'd0;
  localparam logic [1:0] STRETCH = 2'd1;
  localparam logic [1:0] ALIGN   = 2'd2;
  localparam logic [1:0] RUN     = 2'd3;

  logic             s1_q, s2_q;
  logic             db_q, db_d, db_prev_q;
  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic [1:0]       st_q, st_d;
  logic [STR_W-1:0] str_cnt_q, str_cnt_d;
  logic [LP_W-1:0]  lp_cnt_q, lp_cnt_d;
  logic             core_reset_q, ready_q, event_q;
  logic             press;

  // db only follows s2 once it has disagreed for DEBOUNCE_CYCLES consecutive cycles
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (s2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_d     = s2_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DB_ONE;
    end
  end

  assign press = db_prev_q & ~db_q;

  always_comb begin
    st_d      = st_q;
    str_cnt_d = str_cnt_q;
    lp_cnt_d  = lp_cnt_q;
    case (st_q)
      HOLD: begin
        if (db_q) begin
          st_d      = STRETCH;
          str_cnt_d = '0;
        end
      end
      STRETCH: begin
        if (!db_q) begin
          st_d = HOLD;
        end else if (str_cnt_q == STR_LAST) begin
          st_d = (ALIGN_TO_FRAME != 0) ? ALIGN : RUN;
        end else begin
          str_cnt_d = str_cnt_q + STR_ONE;
        end
      end
      ALIGN: begin
        if (!db_q) begin
          st_d = HOLD;
        end else if (frame_start) begin
          st_d = RUN;
        end
      end
      RUN: begin
        if (db_q) begin
          lp_cnt_d = '0;
        end else if (lp_cnt_q == LP_LAST) begin
          st_d     = HOLD;
          lp_cnt_d = '0;
        end else begin
          lp_cnt_d = lp_cnt_q + LP_ONE;
        end
      end
      default: st_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      db_q         <= 1'b1;
      db_prev_q    <= 1'b1;
      db_cnt_q     <= '0;
      st_q         <= HOLD;
      str_cnt_q    <= '0;
      lp_cnt_q     <= '0;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
      event_q      <= 1'b0;
    end else begin
      s1_q         <= button_n;
      s2_q         <= s1_q;
      db_q         <= db_d;
      db_prev_q    <= db_q;
      db_cnt_q     <= db_cnt_d;
      st_q         <= st_d;
      str_cnt_q    <= str_cnt_d;
      lp_cnt_q     <= lp_cnt_d;
      // Outputs come from next-state so they switch on the same edge as state
      core_reset_q <= (st_d != RUN);
      ready_q      <= (st_d == RUN);
      event_q      <= press && (st_q == RUN);
    end
  end

  assign core_reset   = core_reset_q;
  assign ready        = ready_q;
  assign button_event = event_q;
  assign state        = st_q;

endmodule
